// File: rtl/axi_lite_master_bridge.sv
// AXI-Lite initiator: converts single-beat local commands into AXI-Lite write/read
// transactions, one outstanding at a time, returning one response beat per command.
module axi_lite_master_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_we,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
  input  logic [3:0]            i_cmd_wstrb,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_we,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_axi_awaddr,
  output logic                  o_axi_awvalid,
  input  logic                  i_axi_awready,
  output logic [DATA_WIDTH-1:0] o_axi_wdata,
  output logic [3:0]            o_axi_wstrb,
  output logic                  o_axi_wvalid,
  input  logic                  i_axi_wready,
  input  logic                  i_axi_bvalid,
  output logic                  o_axi_bready,
  output logic [ADDR_WIDTH-1:0] o_axi_araddr,
  output logic                  o_axi_arvalid,
  input  logic                  i_axi_arready,
  input  logic [DATA_WIDTH-1:0] i_axi_rdata,
  input  logic                  i_axi_rvalid,
  output logic                  o_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

  state_t                state, state_n;
  logic                  aw_done, aw_done_n;
  logic                  w_done, w_done_n;
  logic                  cmd_ready_n, busy_n;
  logic                  rsp_valid_n, rsp_we_n;
  logic [DATA_WIDTH-1:0] rsp_rdata_n;
  logic [ADDR_WIDTH-1:0] awaddr_n, araddr_n;
  logic [DATA_WIDTH-1:0] wdata_n;
  logic [3:0]            wstrb_n;
  logic                  awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;

  // Every output is a register loaded from its *_n value, so nothing
  // reaches an output combinationally from an input.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      o_cmd_ready   <= 1'b1;
      o_busy        <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_we      <= 1'b0;
      o_rsp_rdata   <= '0;
      o_axi_awaddr  <= '0;
      o_axi_awvalid <= 1'b0;
      o_axi_wdata   <= '0;
      o_axi_wstrb   <= '0;
      o_axi_wvalid  <= 1'b0;
      o_axi_bready  <= 1'b0;
      o_axi_araddr  <= '0;
      o_axi_arvalid <= 1'b0;
      o_axi_rready  <= 1'b0;
    end else begin
      state         <= state_n;
      aw_done       <= aw_done_n;
      w_done        <= w_done_n;
      o_cmd_ready   <= cmd_ready_n;
      o_busy        <= busy_n;
      o_rsp_valid   <= rsp_valid_n;
      o_rsp_we      <= rsp_we_n;
      o_rsp_rdata   <= rsp_rdata_n;
      o_axi_awaddr  <= awaddr_n;
      o_axi_awvalid <= awvalid_n;
      o_axi_wdata   <= wdata_n;
      o_axi_wstrb   <= wstrb_n;
      o_axi_wvalid  <= wvalid_n;
      o_axi_bready  <= bready_n;
      o_axi_araddr  <= araddr_n;
      o_axi_arvalid <= arvalid_n;
      o_axi_rready  <= rready_n;
    end
  end

  always_comb begin
    state_n     = state;
    aw_done_n   = aw_done;
    w_done_n    = w_done;
    rsp_valid_n = o_rsp_valid;
    rsp_we_n    = o_rsp_we;
    rsp_rdata_n = o_rsp_rdata;
    awaddr_n    = o_axi_awaddr;
    awvalid_n   = o_axi_awvalid;
    wdata_n     = o_axi_wdata;
    wstrb_n     = o_axi_wstrb;
    wvalid_n    = o_axi_wvalid;
    bready_n    = o_axi_bready;
    araddr_n    = o_axi_araddr;
    arvalid_n   = o_axi_arvalid;
    rready_n    = o_axi_rready;

    case (state)
      IDLE: begin
        if (i_cmd_valid && o_cmd_ready) begin
          if (i_cmd_we) begin
            awaddr_n  = i_cmd_addr;
            wdata_n   = i_cmd_wdata;
            wstrb_n   = i_cmd_wstrb;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
            state_n   = WR_REQ;
          end else begin
            araddr_n  = i_cmd_addr;
            arvalid_n = 1'b1;
            state_n   = RD_ADDR;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; the done flags let either finish first.
        if (o_axi_awvalid && i_axi_awready) begin
          awvalid_n = 1'b0;
          aw_done_n = 1'b1;
        end
        if (o_axi_wvalid && i_axi_wready) begin
          wvalid_n = 1'b0;
          w_done_n = 1'b1;
        end
        if (aw_done_n && w_done_n) begin
          bready_n = 1'b1;
          state_n  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (i_axi_bvalid && o_axi_bready) begin
          bready_n    = 1'b0;
          rsp_rdata_n = '0;
          rsp_we_n    = 1'b1;
          rsp_valid_n = 1'b1;
          state_n     = RSP;
        end
      end
      RD_ADDR: begin
        if (o_axi_arvalid && i_axi_arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (i_axi_rvalid && o_axi_rready) begin
          rsp_rdata_n = i_axi_rdata;
          rsp_we_n    = 1'b0;
          rready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          state_n     = RSP;
        end
      end
      RSP: begin
        if (i_rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    cmd_ready_n = (state_n == IDLE);
    busy_n      = (state_n != IDLE);
  end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Randomized bench for axi_lite_master_bridge: a flag-level model of the bridge's
// outputs plus an end-to-end memory scoreboard, with a few directed timing checks.
module tb_axi_lite_master_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_ready = 1'b0;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic        bvalid = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = '0;

  logic        o_cmd_ready, o_rsp_valid, o_rsp_we, o_busy;
  logic [31:0] o_rsp_rdata, o_axi_awaddr, o_axi_wdata, o_axi_araddr;
  logic [3:0]  o_axi_wstrb;
  logic        o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_axi_arvalid, o_axi_rready;

  axi_lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(cmd_we),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_we(o_rsp_we), .o_busy(o_busy),
    .o_axi_awaddr(o_axi_awaddr), .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(awready),
    .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb), .o_axi_wvalid(o_axi_wvalid),
    .i_axi_wready(wready), .i_axi_bvalid(bvalid), .o_axi_bready(o_axi_bready),
    .o_axi_araddr(o_axi_araddr), .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(arready),
    .i_axi_rdata(rdata), .i_axi_rvalid(rvalid), .o_axi_rready(o_axi_rready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old_v, logic [31:0] new_v, logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    return r;
  endfunction

  // Responder latencies (cycles a valid/ready waits before the other side answers)
  int unsigned aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0, rsp_lat = 0;
  int unsigned aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0, rsp_cnt = 0;
  logic [31:0] resp_mem [16];
  logic [31:0] ref_mem  [16];
  logic [31:0] hs_awaddr = '0, hs_wdata = '0, hs_araddr = '0;
  logic [3:0]  hs_wstrb = '0;
  logic        aw_got = 1'b0, w_got = 1'b0;

  typedef struct { logic we; logic [31:0] rdata; } exp_t;
  exp_t exp_q[$];
  int   resp_count = 0;
  logic last_rsp_we = 1'b0;
  logic [31:0] last_rsp_rdata = '0;

  // Responder + response scoreboard; all bench inputs change on the falling edge.
  always @(negedge clk) begin
    if (!resetn) begin
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; rsp_cnt = 0;
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rsp_ready = 0;
      aw_got = 0; w_got = 0;
    end else begin
      awready = o_axi_awvalid && (aw_cnt >= aw_lat);
      aw_cnt  = o_axi_awvalid ? aw_cnt + 1 : 0;
      if (awready) begin hs_awaddr = o_axi_awaddr; aw_got = 1; end
      wready = o_axi_wvalid && (w_cnt >= w_lat);
      w_cnt  = o_axi_wvalid ? w_cnt + 1 : 0;
      if (wready) begin hs_wdata = o_axi_wdata; hs_wstrb = o_axi_wstrb; w_got = 1; end
      if (aw_got && w_got) begin
        resp_mem[hs_awaddr[3:0]] = merge(resp_mem[hs_awaddr[3:0]], hs_wdata, hs_wstrb);
        aw_got = 0; w_got = 0;
      end
      arready = o_axi_arvalid && (ar_cnt >= ar_lat);
      ar_cnt  = o_axi_arvalid ? ar_cnt + 1 : 0;
      if (arready) hs_araddr = o_axi_araddr;
      bvalid = o_axi_bready && (b_cnt >= b_lat);
      b_cnt  = o_axi_bready ? b_cnt + 1 : 0;
      rvalid = o_axi_rready && (r_cnt >= r_lat);
      r_cnt  = o_axi_rready ? r_cnt + 1 : 0;
      rdata  = rvalid ? resp_mem[hs_araddr[3:0]] : $urandom;
      rsp_ready = o_rsp_valid && (rsp_cnt >= rsp_lat);
      rsp_cnt   = o_rsp_valid ? rsp_cnt + 1 : 0;
      if (rsp_ready) begin
        resp_count++;
        last_rsp_we = o_rsp_we;
        last_rsp_rdata = o_rsp_rdata;
        chk("rsp_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          chk("sb_rsp_we", o_rsp_we, exp_q[0].we);
          chk("sb_rsp_rdata", o_rsp_rdata, exp_q[0].rdata);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Flag-level model: what each output must be, updated from handshakes.
  logic m_cmd_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, m_rsp_valid, m_rsp_we;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rsp_rdata;
  logic [3:0]  m_wstrb;
  logic acc, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
  int cyc = 0, accepts = 0, acc_cyc = 0, acc_gap = 0;
  logic acc_seen = 1'b0;
  int aw_hi, w_hi, rready_hi, rsp_hi, aw_addr_ok, first_aw, first_w, first_bready, first_rsp;
  int first_rdy, last_rsp_seen = -100;
  logic [31:0] mon_addr = '0;

  task automatic model_reset();
    m_cmd_ready = 1; m_awvalid = 0; m_wvalid = 0; m_bready = 0; m_arvalid = 0;
    m_rready = 0; m_rsp_valid = 0; m_rsp_we = 0; m_rsp_rdata = '0;
    m_awaddr = '0; m_wdata = '0; m_araddr = '0; m_wstrb = '0;
    exp_q.delete();
  endtask

  initial model_reset();

  always @(posedge clk) begin
    cyc++;
    if (!resetn) model_reset();
    else begin
      acc    = m_cmd_ready && cmd_valid;
      aw_hs  = m_awvalid && awready;
      w_hs   = m_wvalid && wready;
      b_hs   = m_bready && bvalid;
      ar_hs  = m_arvalid && arready;
      r_hs   = m_rready && rvalid;
      rsp_hs = m_rsp_valid && rsp_ready;
      if (acc) begin
        accepts++; acc_cyc = cyc - 1; acc_seen = 1; acc_gap = acc_cyc - last_rsp_seen;
        m_cmd_ready = 0;
        if (cmd_we) begin
          m_awvalid = 1; m_wvalid = 1;
          m_awaddr = cmd_addr; m_wdata = cmd_wdata; m_wstrb = cmd_wstrb;
          ref_mem[cmd_addr[3:0]] = merge(ref_mem[cmd_addr[3:0]], cmd_wdata, cmd_wstrb);
          exp_q.push_back('{we: 1'b1, rdata: 32'h0});
        end else begin
          m_arvalid = 1; m_araddr = cmd_addr;
          exp_q.push_back('{we: 1'b0, rdata: ref_mem[cmd_addr[3:0]]});
        end
      end
      if (aw_hs) m_awvalid = 0;
      if (w_hs)  m_wvalid = 0;
      if ((aw_hs || w_hs) && !m_awvalid && !m_wvalid) m_bready = 1;
      if (b_hs) begin m_bready = 0; m_rsp_valid = 1; m_rsp_rdata = '0; m_rsp_we = 1; end
      if (ar_hs) begin m_arvalid = 0; m_rready = 1; end
      if (r_hs) begin m_rready = 0; m_rsp_valid = 1; m_rsp_rdata = rdata; m_rsp_we = 0; end
      if (rsp_hs) begin m_rsp_valid = 0; m_cmd_ready = 1; end
    end
    #1;
    chk("ctl{cmd_ready,busy,aw,w,b,ar,r,rsp}",
        {o_cmd_ready, o_busy, o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_axi_arvalid, o_axi_rready, o_rsp_valid},
        {m_cmd_ready, !m_cmd_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, m_rsp_valid});
    if (m_awvalid) chk("awaddr", o_axi_awaddr, m_awaddr);
    if (m_wvalid) chk("wdata/wstrb", {o_axi_wstrb, o_axi_wdata}, {m_wstrb, m_wdata});
    if (m_arvalid) chk("araddr", o_axi_araddr, m_araddr);
    if (m_rsp_valid) chk("rsp_data/we", {o_rsp_we, o_rsp_rdata}, {m_rsp_we, m_rsp_rdata});
    if (o_axi_awvalid) begin
      aw_hi++; if (first_aw < 0) first_aw = cyc;
      if (o_axi_awaddr == mon_addr) aw_addr_ok++;
    end
    if (o_axi_wvalid) begin w_hi++; if (first_w < 0) first_w = cyc; end
    if (o_axi_bready && first_bready < 0) first_bready = cyc;
    if (o_axi_rready) rready_hi++;
    if (o_rsp_valid) begin rsp_hi++; last_rsp_seen = cyc; if (first_rsp < 0) first_rsp = cyc; end
    if (acc_seen && cyc > acc_cyc && o_cmd_ready && first_rdy < 0) first_rdy = cyc;
  end

  task automatic clear_mon(input logic [31:0] a);
    aw_hi = 0; w_hi = 0; rready_hi = 0; rsp_hi = 0; aw_addr_ok = 0;
    first_aw = -1; first_w = -1; first_bready = -1; first_rsp = -1; first_rdy = -1;
    acc_seen = 0; mon_addr = a;
  endtask

  task automatic set_lat(input int unsigned aw, input int unsigned w, input int unsigned ar,
                         input int unsigned b, input int unsigned r, input int unsigned rs);
    aw_lat = aw; w_lat = w; ar_lat = ar; b_lat = b; r_lat = r; rsp_lat = rs;
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int unsigned guard;
    guard = 0;
    cmd_valid = 1; cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    while (!o_cmd_ready && guard < 2000) begin @(negedge clk); guard++; end
    if (guard >= 2000) chk("cmd_accept_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 0; cmd_we = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = $urandom;
  endtask

  task automatic wait_idle();
    int unsigned guard;
    guard = 0;
    while (!(o_cmd_ready && exp_q.size() == 0) && guard < 2000) begin @(negedge clk); guard++; end
    if (guard >= 2000) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int base;
    for (int i = 0; i < 16; i++) begin resp_mem[i] = '0; ref_mem[i] = '0; end
    repeat (3) @(negedge clk);
    chk("reset_ctl", {o_cmd_ready, o_busy, o_axi_awvalid, o_axi_wvalid, o_axi_bready,
                      o_axi_arvalid, o_axi_rready, o_rsp_valid}, 8'b1000_0000);
    chk("reset_regs", {o_rsp_we, o_rsp_rdata, o_axi_awaddr, o_axi_wdata, o_axi_araddr, o_axi_wstrb}, 0);
    #2 resetn = 1;
    @(negedge clk);

    // Divisor write, zero-wait responder
    set_lat(0, 0, 0, 0, 0, 0); clear_mon(32'h1);
    issue(1, 32'h1, 32'h145, 4'hF); wait_idle();
    chk("t1_aw_offset", first_aw - acc_cyc, 1);
    chk("t1_w_offset", first_w - acc_cyc, 1);
    chk("t1_bready_offset", first_bready - acc_cyc, 2);
    chk("t1_rsp_offset", first_rsp - acc_cyc, 3);
    chk("t1_rsp", {last_rsp_we, last_rsp_rdata}, {1'b1, 32'h0});
    chk("t1_divisor", resp_mem[1], 32'h145);

    // TX data write with awready held off 3 cycles
    set_lat(3, 0, 0, 0, 0, 0); clear_mon(32'h2); base = resp_count;
    issue(1, 32'h2, 32'h55, 4'hF); wait_idle();
    chk("t2_aw_cycles", aw_hi, 4);
    chk("t2_awaddr_stable", aw_addr_ok, 4);
    chk("t2_w_cycles", w_hi, 1);
    chk("t2_bready_offset", first_bready - acc_cyc, 5);
    chk("t2_one_rsp", resp_count - base, 1);
    chk("t2_txdata", resp_mem[2], 32'h55);

    // RX read with rvalid 5 cycles late
    resp_mem[3] = 32'h1A5; ref_mem[3] = 32'h1A5;
    set_lat(0, 0, 0, 0, 5, 0); clear_mon(32'h3);
    issue(0, 32'h3, 32'h0, 4'h0); wait_idle();
    chk("t3_rready_cycles", rready_hi, 6);
    chk("t3_rsp_offset", first_rsp - acc_cyc, 8);
    chk("t3_rsp", {last_rsp_we, last_rsp_rdata}, {1'b0, 32'h1A5});

    // Response backpressure for 4 cycles
    set_lat(0, 0, 0, 0, 0, 4); clear_mon(32'h3);
    issue(0, 32'h3, 32'h0, 4'h0); wait_idle();
    chk("t4_rsp_cycles", rsp_hi, 5);
    chk("t4_cmd_ready_back", first_rdy - acc_cyc, 8);
    chk("t4_rsp", last_rsp_rdata, 32'h1A5);

    // Back-to-back: second command held while the first runs
    set_lat(0, 0, 0, 0, 0, 0); clear_mon(32'h5);
    issue(1, 32'h5, 32'hDEADBEEF, 4'hF);
    issue(0, 32'h5, 32'h0, 4'h0);
    chk("t5_accept_gap", acc_gap, 1);
    wait_idle();
    chk("t5_readback", {last_rsp_we, last_rsp_rdata}, {1'b0, 32'hDEADBEEF});

    // Reset while waiting for the write response
    set_lat(0, 0, 0, 20, 0, 0); clear_mon(32'h6); base = resp_count;
    issue(1, 32'h6, 32'h99, 4'hF);
    for (int g = 0; g < 50 && !o_axi_bready; g++) @(negedge clk);
    chk("t6_in_wr_resp", o_axi_bready, 1);
    #2 resetn = 0;
    #1;
    chk("t6_reset_ctl", {o_cmd_ready, o_busy, o_axi_awvalid, o_axi_wvalid, o_axi_bready,
                         o_axi_arvalid, o_axi_rready, o_rsp_valid}, 8'b1000_0000);
    @(negedge clk); @(negedge clk);
    #2 resetn = 1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    chk("t6_no_rsp", resp_count - base, 0);
    set_lat(0, 0, 0, 0, 0, 0);
    issue(1, 32'h1, 32'h77, 4'h1); wait_idle();
    chk("t6_next_write_rsp", resp_count - base, 1);
    chk("t6_next_write_mem", resp_mem[1], 32'h177);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      set_lat($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 3));
      issue($urandom_range(0, 1), ($urandom & 32'h0F0F_0000) | $urandom_range(0, 15), $urandom, 4'($urandom));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_rsp_count", resp_count, accepts - 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/axi_lite_master_bridge.md
Name: axi_lite_master_bridge

Overview:
AXI-Lite initiator that turns single-beat commands from a local command port into AXI-Lite write or read transactions. It drives the AW, W, B, AR and R channels toward any AXI-Lite responder in the design, for example the UART peripheral.
- Register map used on that UART: 0x1 = divisor, 0x2 = TX data, 0x3 = RX pop/status.
- Exactly one transaction is outstanding at a time.
- Each completed transaction returns one response beat to the command issuer.

Parameters:
ADDR_WIDTH, 32, width of command address and AXI AW/AR address.
DATA_WIDTH, 32, width of command data and AXI W/R data.

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  reset, asynchronous assert, active-low
i_cmd_valid  input  1  command present
o_cmd_ready  output  1  bridge can accept a command (high only in IDLE)
i_cmd_we  input  1  1 = write, 0 = read
i_cmd_addr  input  ADDR_WIDTH  transaction address
i_cmd_wdata  input  DATA_WIDTH  write data
i_cmd_wstrb  input  4  write byte strobes
o_rsp_valid  output  1  response beat available
i_rsp_ready  input  1  issuer accepts response
o_rsp_rdata  output  DATA_WIDTH  read data; zero after a write
o_rsp_we  output  1  echoes i_cmd_we of the completed command
o_busy  output  1  high whenever state is not IDLE
o_axi_awaddr  output  ADDR_WIDTH  write address
o_axi_awvalid  output  1  write address valid
i_axi_awready  input  1  write address ready
o_axi_wdata  output  DATA_WIDTH  write data
o_axi_wstrb  output  4  write strobes
o_axi_wvalid  output  1  write data valid
i_axi_wready  input  1  write data ready
i_axi_bvalid  input  1  write response valid
o_axi_bready  output  1  write response ready
o_axi_araddr  output  ADDR_WIDTH  read address
o_axi_arvalid  output  1  read address valid
i_axi_arready  input  1  read address ready
i_axi_rdata  input  DATA_WIDTH  read data
i_axi_rvalid  input  1  read data valid
o_axi_rready  output  1  read data ready

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE; every valid/ready output = 0 except o_cmd_ready = 1.
  - All address, data, strobe and o_rsp_rdata registers = 0; o_rsp_we = 0; o_busy = 0.
  - Reset mid-transaction abandons it without completing any handshake.
- All AXI and response outputs are registered; nothing passes combinationally from input to output.
- IDLE: on i_cmd_valid && o_cmd_ready, capture addr, wdata, wstrb and we.
  - Write goes to WR_REQ: next cycle awvalid = 1 and wvalid = 1.
  - Read goes to RD_ADDR: next cycle arvalid = 1.
- WR_REQ:
  - awvalid falls the cycle after awvalid && awready; wvalid falls the cycle after wvalid && wready.
  - The two channels complete independently, in either order or the same cycle. A per-channel done flag records each.
  - When both are done, go to WR_RESP with bready = 1.
  - Valid is never withdrawn before its handshake, and address/data stay stable while valid is high.
- WR_RESP: bready = 1. On bvalid, bready falls, rsp_rdata = 0, rsp_we = 1, go to RSP.
- RD_ADDR: on arvalid && arready, arvalid falls and rready rises; go to RD_DATA.
- RD_DATA: on rvalid && rready, rsp_rdata = rdata, rsp_we = 0, rready falls, go to RSP.
- RSP: o_rsp_valid = 1 and held stable until i_rsp_ready; then o_rsp_valid falls and state returns to IDLE (o_cmd_ready = 1 the next cycle).
- Commands arriving while not in IDLE are not accepted (o_cmd_ready = 0); the issuer holds them.
- Zero-wait responder, command accepted at cycle 0:
  - Write: AW/W valid at cycle 1, bready at cycle 2, rsp_valid at cycle 3 if bvalid is already high at cycle 2.
  - Read: arvalid at cycle 1, rready at cycle 2, rsp_valid at cycle 3.
- No timeout. A responder that never answers stalls the bridge until reset.
- Stalls of arbitrary length on any ready/valid input are tolerated with no loss or duplication.

Test Plan:
- Write addr 0x1 data 0x145 wstrb 0xF, responder always ready, bvalid one cycle after both handshakes -> one AW and one W handshake at cycle 1; rsp_valid with rsp_we = 1 and rdata = 0 at cycle 3 after bvalid; UART divisor = 0x145.
- Write addr 0x2 data 0x55 with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle; awvalid held 4 cycles with awaddr stable at 0x2; bready asserted only after AW completes; exactly one response.
- Read addr 0x3, arready immediate, rvalid delayed 5 cycles with rdata 0x1A5 -> rready held high through the wait; rsp_rdata = 0x1A5, rsp_we = 0.
- Response backpressure: i_rsp_ready low 4 cycles after a read -> o_rsp_valid and o_rsp_rdata stable for all 4 cycles; o_cmd_ready = 0 until the cycle after acceptance.
- Back-to-back: second command held valid during the first transaction -> accepted only in the IDLE cycle after the first response; no overlap of AXI valids between the two transactions.
- resetn pulsed low during WR_RESP -> all valids/readies drop immediately, o_cmd_ready = 1, no response emitted; the next write completes normally.
